noc_router: RTL and testbench
=============================

Name: noc_router

Overview:
- One virtual-channel (VC) router node of the mesh/graph NoC.
- The top-level sequencer drives it through an opcode bus: configure, load routing table, then repeat a three-op cycle: LoadStaging, Phase0 (allocate), Phase1 (traverse).
- Flits and credits travel between routers through per-port staging words.
- Port 0 is the local injection/ejection port.

Parameters:
- MAXIO, 5, max in/out ports (port 0 = local).
- MAXVC, 4, max VCs per port.
- BUF_DEPTH, 4, flit slots per input VC buffer (power of 2).
- RTR_W, 4, router-id width (up to 16 routers).
- PAYLOAD_W, 16, flit payload width.
- CYC_W, 16, in_cycle width.
- CDLY_W, 3, credit-delay width; credit FIFO depth 2^CDLY_W.
- Derived: PORT_W=clog2(MAXIO+1), VC_W=clog2(MAXVC), BUF_W=1+VC_W+RTR_W+PAYLOAD_W, DATA_W=2*PORT_W+VC_W+1+CDLY_W, OP_W=3.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- out_staging  out  MAXIO*BUF_W  outgoing flit per output port (slot j = bits j*BUF_W +: BUF_W)
- out_cr_staging  out  MAXIO*BUF_W  credit returned upstream per input port
- done  out  1  router idle
- can_inject  out  MAXVC  local VC v may accept one flit
- router_op  in  OP_W  NOP=0, Init=1, LoadRt=2, LoadStaging=3, Phase0=4, Phase1=5; others = NOP
- in_staging  in  MAXIO*BUF_W  incoming flit per input port
- in_cr_staging  in  MAXIO*BUF_W  incoming credit per output port
- router_data  in  DATA_W  op argument
- in_cycle  in  CYC_W  global cycle count

Behaviour:
- Flit word: bit0 = valid, then vc[VC_W], dst[RTR_W], payload (LSB first).
- Credit word: bit0 = valid, vc at bits [VC_W:1], rest 0.
- All ops execute on the posedge clk where router_op is sampled.
- Reset (async):
  - buffers, routing table and credit FIFOs are cleared.
  - out_staging = 0, out_cr_staging = 0, done = 1, can_inject = 0.
  - Configuration registers are cleared.
- Init:
  - router_data fields, LSB first: num_in_ports[PORT_W], num_out_ports[PORT_W], num_vcs[VC_W+1], credit_delay[CDLY_W].
  - Clears buffers and grants.
  - Sets credit[o][v] = BUF_DEPTH for v<num_vcs and 0 otherwise.
- LoadRt:
  - Fields: out_port[PORT_W] LSB, then dst[RTR_W].
  - Writes rt[dst] = out_port and marks the entry valid.
- LoadStaging:
  - For each p<num_in_ports with a valid flit: push it into buf[p][vc]. A flit arriving at a full buffer is dropped.
  - For each o<num_out_ports with a valid credit: credit[o][vc]++, saturating at BUF_DEPTH.
- Phase0:
  - Each non-empty buf[p][v] whose head dst has a valid rt entry requests output o = rt[dst].
  - A request is eligible if credit[o][v] > 0; output 0 (ejection) always has credit.
  - Per output: round-robin over (p,v) requests, pointer advances past the winner.
  - Each input port receives at most one grant; lowest output index resolves a conflict.
  - Grants are registered.
  - Heads with an invalid route never request.
- Phase1:
  - For each grant: pop the head flit, drive it on out_staging[o], decrement credit[o][v] (not for o=0).
  - For each grant, push {p, v, in_cycle} into credit FIFO p.
  - Ungranted out_staging slots = 0.
  - For each p: if the FIFO head satisfies in_cycle - stamp >= credit_delay (CYC_W wrap arithmetic), pop it and drive out_cr_staging[p] valid with that vc; otherwise drive 0.
  - Grants are then cleared.
- Outputs hold their value between Phase1 ops; NOP changes nothing.
- can_inject[v] = (v<num_vcs) and buf[0][v] not full; updated every cycle.
- done = all buffers empty, no grants, all credit FIFOs empty.

Decomposition:
- Package noc_pkg: opcode constants, flit/credit field offsets and widths, router_data field offsets.
- One sub-module, noc_vc_fifo: per-(port,VC) flit FIFO with full/empty.

Test Plan:
- Reset mid-run (rst=1 while buffers hold flits) -> done=1, out_staging=0, can_inject=0 immediately, without waiting for a clock edge.
- Init in=3, out=3, vcs=2, delay=0; LoadRt rt[5]=2; flit {vc1,dst5} on in port 1 -> after LoadStaging/Phase0/Phase1: out_staging slot2 holds the flit; out_cr_staging slot1 = valid, vc1.
- Same setup with delay=2, in_cycle stamped 10 -> credit appears on the first Phase1 with in_cycle >= 12, not before.
- Five flits to out port 2 on VC0 with no returned credits -> exactly 4 delivered, 5th blocked; one in_cr_staging credit {vc0} releases it the next cycle.
- Ports 1 and 2 both target out port 3 for 2 cycles -> grants alternate 1 then 2.
- Fill buf[0][1] with 4 flits -> can_inject[1]=0, can_inject[0]=1; after the pop, can_inject[1]=1 again.

Source files
------------

// File: rtl/noc_pkg.sv
// noc_pkg: shared parameters, opcodes and field offsets for the NoC router node
package noc_pkg;
  localparam int MAXIO     = 5;
  localparam int MAXVC     = 4;
  localparam int BUF_DEPTH = 4;
  localparam int RTR_W     = 4;
  localparam int PAYLOAD_W = 16;
  localparam int CYC_W     = 16;
  localparam int CDLY_W    = 3;
  localparam int PORT_W    = $clog2(MAXIO + 1);
  localparam int VC_W      = $clog2(MAXVC);
  localparam int BUF_W     = 1 + VC_W + RTR_W + PAYLOAD_W;
  localparam int DATA_W    = 2 * PORT_W + VC_W + 1 + CDLY_W;
  localparam int OP_W      = 3;
  localparam int CNT_W     = $clog2(BUF_DEPTH + 1);
  localparam int CF_DEPTH  = 2 ** CDLY_W;
  localparam int NREQ      = MAXIO * MAXVC;
  localparam int RR_W      = $clog2(NREQ);
  typedef enum logic [OP_W-1:0] {
    OP_NOP = 3'd0, OP_INIT = 3'd1, OP_LOAD_RT = 3'd2,
    OP_LOAD_STG = 3'd3, OP_PHASE0 = 3'd4, OP_PHASE1 = 3'd5
  } op_e;
  localparam int F_VLD     = 0;
  localparam int F_VC      = 1;
  localparam int F_DST     = 1 + VC_W;
  localparam int F_PAY     = 1 + VC_W + RTR_W;
  localparam int D_NIN     = 0;
  localparam int D_NOUT    = PORT_W;
  localparam int D_NVC     = 2 * PORT_W;
  localparam int D_CDLY    = 2 * PORT_W + VC_W + 1;
  localparam int D_RT_PORT = 0;
  localparam int D_RT_DST  = PORT_W;
endpackage

// File: rtl/noc_vc_fifo.sv
// noc_vc_fifo: flit FIFO for one (input port, VC) pair; pushes into a full FIFO are dropped
module noc_vc_fifo
  import noc_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             push,
  input  logic             pop,
  input  logic [BUF_W-1:0] din,
  output logic [BUF_W-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(BUF_DEPTH);
  logic [BUF_W-1:0] mem_q [BUF_DEPTH];
  logic [BUF_W-1:0] mem_d [BUF_DEPTH];
  logic [AW-1:0] rp_q, rp_d, wp_q, wp_d;
  logic [AW:0] cnt_q, cnt_d;
  logic wr, rd;
  assign full  = cnt_q == (AW+1)'(BUF_DEPTH);
  assign empty = cnt_q == '0;
  assign dout  = mem_q[rp_q];
  assign wr    = push && !full;
  assign rd    = pop && !empty;
  always_comb begin
    mem_d = mem_q;
    if (wr) mem_d[wp_q] = din;
    wp_d  = clr ? '0 : wp_q + AW'(wr);
    rp_d  = clr ? '0 : rp_q + AW'(rd);
    cnt_d = clr ? '0 : cnt_q + (AW+1)'(wr) - (AW+1)'(rd);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q <= '{default: '0};
      rp_q  <= '0;
      wp_q  <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      rp_q  <= rp_d;
      wp_q  <= wp_d;
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: rtl/noc_router.sv
// noc_router: one virtual-channel router node sequenced by the opcode bus
// (configure, load routes, then LoadStaging / Phase0 allocate / Phase1 traverse).
module noc_router
  import noc_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  output logic [MAXIO*BUF_W-1:0] out_staging,
  output logic [MAXIO*BUF_W-1:0] out_cr_staging,
  output logic                   done,
  output logic [MAXVC-1:0]       can_inject,
  input  logic [OP_W-1:0]        router_op,
  input  logic [MAXIO*BUF_W-1:0] in_staging,
  input  logic [MAXIO*BUF_W-1:0] in_cr_staging,
  input  logic [DATA_W-1:0]      router_data,
  input  logic [CYC_W-1:0]       in_cycle
);
  localparam int NRT  = 2 ** RTR_W;
  localparam int CF_W = VC_W + CYC_W;
  op_e op;
  logic [PORT_W-1:0] nin_q, nin_d, nout_q, nout_d;
  logic [VC_W:0] nvc_q, nvc_d;
  logic [CDLY_W-1:0] cdly_q, cdly_d;
  logic [PORT_W-1:0] rt_q [NRT];
  logic [PORT_W-1:0] rt_d [NRT];
  logic [NRT-1:0] rt_vld_q, rt_vld_d;
  logic [CNT_W-1:0] cred_q [MAXIO][MAXVC];
  logic [CNT_W-1:0] cred_d [MAXIO][MAXVC];
  logic [RR_W-1:0] rr_q [MAXIO];
  logic [RR_W-1:0] rr_d [MAXIO];
  logic [MAXIO-1:0] g_vld_q, g_vld_d;
  logic [PORT_W-1:0] g_p_q [MAXIO];
  logic [PORT_W-1:0] g_p_d [MAXIO];
  logic [VC_W-1:0] g_v_q [MAXIO];
  logic [VC_W-1:0] g_v_d [MAXIO];
  logic [CF_W-1:0] cf_mem_q [MAXIO][CF_DEPTH];
  logic [CF_W-1:0] cf_mem_d [MAXIO][CF_DEPTH];
  logic [CDLY_W-1:0] cf_rp_q [MAXIO];
  logic [CDLY_W-1:0] cf_rp_d [MAXIO];
  logic [CDLY_W-1:0] cf_wp_q [MAXIO];
  logic [CDLY_W-1:0] cf_wp_d [MAXIO];
  logic [CDLY_W:0] cf_cnt_q [MAXIO];
  logic [CDLY_W:0] cf_cnt_d [MAXIO];
  logic [MAXIO*BUF_W-1:0] out_stg_q, out_stg_d, out_cr_q, out_cr_d;
  logic [MAXIO-1:0][MAXVC-1:0] push, pop, full, empty;
  logic [BUF_W-1:0] head [MAXIO][MAXVC];
  logic [MAXIO-1:0][NREQ-1:0] req;
  logic [MAXIO-1:0] taken, cf_push, cf_have, cf_pop, cf_st;
  logic [VC_W-1:0] cf_pvc [MAXIO];
  logic [CF_W-1:0] cf_head [MAXIO];
  logic [CYC_W-1:0] age [MAXIO];
  logic cf_idle, found;
  int sel, idx;
  assign op             = op_e'(router_op);
  assign out_staging    = out_stg_q;
  assign out_cr_staging = out_cr_q;
  assign done           = (empty == '1) && !(|g_vld_q) && cf_idle;
  for (genvar i = 0; i < MAXIO; i++) begin : g_port
    for (genvar j = 0; j < MAXVC; j++) begin : g_vc
      noc_vc_fifo u_fifo (
        .clk  (clk),
        .rst  (rst),
        .clr  (op == OP_INIT),
        .push (push[i][j]),
        .pop  (pop[i][j]),
        .din  (in_staging[i*BUF_W +: BUF_W]),
        .dout (head[i][j]),
        .full (full[i][j]),
        .empty(empty[i][j])
      );
    end
  end
  always_comb begin
    push    = '0;
    pop     = '0;
    cf_push = '0;
    cf_idle = 1'b1;
    for (int v = 0; v < MAXVC; v++)
      can_inject[v] = ((VC_W+1)'(v) < nvc_q) && !full[0][v];
    for (int p = 0; p < MAXIO; p++) begin
      cf_pvc[p] = '0;
      if (cf_cnt_q[p] != '0) cf_idle = 1'b0;
      if (op == OP_LOAD_STG && PORT_W'(p) < nin_q && in_staging[p*BUF_W+F_VLD])
        push[p][in_staging[p*BUF_W+F_VC +: VC_W]] = 1'b1;
    end
    for (int o = 0; o < MAXIO; o++)
      if (op == OP_PHASE1 && g_vld_q[o]) begin
        pop[g_p_q[o]][g_v_q[o]] = 1'b1;
        cf_push[g_p_q[o]]       = 1'b1;
        cf_pvc[g_p_q[o]]        = g_v_q[o];
      end
    // ejection (output 0) never runs out of credit
    for (int o = 0; o < MAXIO; o++)
      for (int p = 0; p < MAXIO; p++)
        for (int v = 0; v < MAXVC; v++)
          req[o][p*MAXVC+v] = PORT_W'(p) < nin_q && !empty[p][v]
                              && rt_vld_q[head[p][v][F_DST +: RTR_W]]
                              && rt_q[head[p][v][F_DST +: RTR_W]] == PORT_W'(o)
                              && (o == 0 || cred_q[o][v] != '0);
  end
  always_comb begin
    nin_d    = nin_q;
    nout_d   = nout_q;
    nvc_d    = nvc_q;
    cdly_d   = cdly_q;
    rt_d     = rt_q;
    rt_vld_d = rt_vld_q;
    cred_d   = cred_q;
    rr_d     = rr_q;
    g_vld_d  = g_vld_q;
    g_p_d    = g_p_q;
    g_v_d    = g_v_q;
    cf_mem_d = cf_mem_q;
    cf_rp_d  = cf_rp_q;
    cf_wp_d  = cf_wp_q;
    cf_cnt_d = cf_cnt_q;
    out_stg_d = out_stg_q;
    out_cr_d  = out_cr_q;
    taken    = '0;
    found    = 1'b0;
    sel      = 0;
    idx      = 0;
    for (int p = 0; p < MAXIO; p++) begin
      cf_have[p] = cf_cnt_q[p] != '0;
      cf_head[p] = cf_have[p] ? cf_mem_q[p][cf_rp_q[p]] : {cf_pvc[p], in_cycle};
      age[p]     = in_cycle - cf_head[p][CYC_W-1:0];
      cf_pop[p]  = (cf_have[p] || cf_push[p]) && age[p] >= CYC_W'(cdly_q);
      cf_st[p]   = cf_push[p] && (cf_have[p] || !cf_pop[p])
                   && cf_cnt_q[p] != (CDLY_W+1)'(CF_DEPTH);
    end
    if (op == OP_INIT) begin
      nin_d   = router_data[D_NIN +: PORT_W];
      nout_d  = router_data[D_NOUT +: PORT_W];
      nvc_d   = router_data[D_NVC +: VC_W+1];
      cdly_d  = router_data[D_CDLY +: CDLY_W];
      g_vld_d = '0;
      for (int o = 0; o < MAXIO; o++)
        for (int v = 0; v < MAXVC; v++)
          cred_d[o][v] = ((VC_W+1)'(v) < router_data[D_NVC +: VC_W+1]) ? CNT_W'(BUF_DEPTH) : '0;
    end
    if (op == OP_LOAD_RT) begin
      rt_d[router_data[D_RT_DST +: RTR_W]]     = router_data[D_RT_PORT +: PORT_W];
      rt_vld_d[router_data[D_RT_DST +: RTR_W]] = 1'b1;
    end
    if (op == OP_LOAD_STG)
      for (int o = 0; o < MAXIO; o++)
        for (int v = 0; v < MAXVC; v++)
          if (PORT_W'(o) < nout_q && in_cr_staging[o*BUF_W+F_VLD]
              && in_cr_staging[o*BUF_W+F_VC +: VC_W] == VC_W'(v)
              && cred_q[o][v] != CNT_W'(BUF_DEPTH))
            cred_d[o][v] = cred_q[o][v] + 1'b1;
    // outputs allocate in index order so the lowest output wins a contested input
    if (op == OP_PHASE0) begin
      g_vld_d = '0;
      for (int o = 0; o < MAXIO; o++) begin
        found = 1'b0;
        sel   = 0;
        for (int k = 0; k < NREQ; k++) begin
          idx = (int'(rr_q[o]) + k) % NREQ;
          if (!found && req[o][idx] && !taken[idx/MAXVC]) begin
            found = 1'b1;
            sel   = idx;
          end
        end
        if (found) begin
          g_vld_d[o]         = 1'b1;
          g_p_d[o]           = PORT_W'(sel / MAXVC);
          g_v_d[o]           = VC_W'(sel % MAXVC);
          taken[sel / MAXVC] = 1'b1;
          rr_d[o]            = (sel == NREQ - 1) ? '0 : RR_W'(sel + 1);
        end
      end
    end
    if (op == OP_PHASE1) begin
      g_vld_d   = '0;
      out_stg_d = '0;
      out_cr_d  = '0;
      for (int o = 0; o < MAXIO; o++)
        if (g_vld_q[o]) begin
          out_stg_d[o*BUF_W +: BUF_W] = head[g_p_q[o]][g_v_q[o]];
          if (o != 0 && cred_q[o][g_v_q[o]] != '0)
            cred_d[o][g_v_q[o]] = cred_q[o][g_v_q[o]] - 1'b1;
        end
      // an empty credit FIFO lets a fresh entry bypass straight to the output
      for (int p = 0; p < MAXIO; p++) begin
        if (cf_pop[p]) out_cr_d[p*BUF_W +: BUF_W] = BUF_W'({cf_head[p][CF_W-1 -: VC_W], 1'b1});
        if (cf_st[p]) begin
          cf_mem_d[p][cf_wp_q[p]] = {cf_pvc[p], in_cycle};
          cf_wp_d[p] = cf_wp_q[p] + 1'b1;
        end
        if (cf_pop[p] && cf_have[p]) cf_rp_d[p] = cf_rp_q[p] + 1'b1;
        cf_cnt_d[p] = cf_cnt_q[p] + (CDLY_W+1)'(cf_st[p]) - (CDLY_W+1)'(cf_pop[p] && cf_have[p]);
      end
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      nin_q     <= '0;
      nout_q    <= '0;
      nvc_q     <= '0;
      cdly_q    <= '0;
      rt_q      <= '{default: '0};
      rt_vld_q  <= '0;
      cred_q    <= '{default: '0};
      rr_q      <= '{default: '0};
      g_vld_q   <= '0;
      g_p_q     <= '{default: '0};
      g_v_q     <= '{default: '0};
      cf_mem_q  <= '{default: '0};
      cf_rp_q   <= '{default: '0};
      cf_wp_q   <= '{default: '0};
      cf_cnt_q  <= '{default: '0};
      out_stg_q <= '0;
      out_cr_q  <= '0;
    end else begin
      nin_q     <= nin_d;
      nout_q    <= nout_d;
      nvc_q     <= nvc_d;
      cdly_q    <= cdly_d;
      rt_q      <= rt_d;
      rt_vld_q  <= rt_vld_d;
      cred_q    <= cred_d;
      rr_q      <= rr_d;
      g_vld_q   <= g_vld_d;
      g_p_q     <= g_p_d;
      g_v_q     <= g_v_d;
      cf_mem_q  <= cf_mem_d;
      cf_rp_q   <= cf_rp_d;
      cf_wp_q   <= cf_wp_d;
      cf_cnt_q  <= cf_cnt_d;
      out_stg_q <= out_stg_d;
      out_cr_q  <= out_cr_d;
    end
  end
endmodule

// File: tb/tb_noc_router.sv
// tb_noc_router: directed checks of routing, credits, arbitration and injection backpressure
module tb_noc_router;
  import noc_pkg::*;
  localparam int SW = MAXIO * BUF_W;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [SW-1:0] out_staging, out_cr_staging, in_staging, in_cr_staging;
  logic done;
  logic [MAXVC-1:0] can_inject;
  logic [OP_W-1:0] router_op;
  logic [DATA_W-1:0] router_data;
  logic [CYC_W-1:0] in_cycle;
  int n_tests = 0;
  int n_fail = 0;
  noc_router dut (
    .clk(clk), .rst(rst), .out_staging(out_staging), .out_cr_staging(out_cr_staging),
    .done(done), .can_inject(can_inject), .router_op(router_op), .in_staging(in_staging),
    .in_cr_staging(in_cr_staging), .router_data(router_data), .in_cycle(in_cycle)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic logic [BUF_W-1:0] flit(input int vc, input int dst, input int pay);
    return {PAYLOAD_W'(pay), RTR_W'(dst), VC_W'(vc), 1'b1};
  endfunction
  function automatic logic [BUF_W-1:0] cr(input int vc);
    return BUF_W'({VC_W'(vc), 1'b1});
  endfunction
  function automatic logic [SW-1:0] slot(input int j, input logic [BUF_W-1:0] w);
    return SW'(w) << (j * BUF_W);
  endfunction
  task automatic do_op(input op_e o, input logic [DATA_W-1:0] d);
    @(negedge clk);
    router_op   = o;
    router_data = d;
    @(posedge clk);
    #1;
    router_op     = OP_NOP;
    router_data   = '0;
    in_staging    = '0;
    in_cr_staging = '0;
  endtask
  task automatic init(input int ni, input int no, input int nv, input int dl);
    do_op(OP_INIT, DATA_W'((dl << D_CDLY) | (nv << D_NVC) | (no << D_NOUT) | ni));
  endtask
  task automatic load_rt(input int dst, input int port);
    do_op(OP_LOAD_RT, DATA_W'((dst << D_RT_DST) | port));
  endtask
  task automatic route(input int cyc);
    do_op(OP_LOAD_STG, '0);
    do_op(OP_PHASE0, '0);
    in_cycle = CYC_W'(cyc);
    do_op(OP_PHASE1, '0);
  endtask
  initial begin
    router_op = '0; router_data = '0; in_staging = '0; in_cr_staging = '0; in_cycle = '0;
    #1 rst = 1'b1;
    #1;
    check("rst_done", done, 1);
    check("rst_out", out_staging, 0);
    check("rst_cr", out_cr_staging, 0);
    check("rst_inj", can_inject, 0);
    @(negedge clk);
    rst = 1'b0;
    init(3, 3, 2, 0);
    check("init_inj", can_inject, 4'b0011);
    load_rt(5, 2);
    in_staging = slot(1, flit(1, 5, 16'hABCD));
    do_op(OP_LOAD_STG, '0);
    check("busy_done", done, 0);
    do_op(OP_PHASE0, '0);
    do_op(OP_PHASE1, '0);
    check("fwd_out", out_staging, slot(2, flit(1, 5, 16'hABCD)));
    check("fwd_cr", out_cr_staging, slot(1, cr(1)));
    check("fwd_done", done, 1);
    init(3, 3, 2, 2);
    in_staging = slot(1, flit(1, 5, 16'h1234));
    route(10);
    check("dly_out", out_staging, slot(2, flit(1, 5, 16'h1234)));
    check("dly_cr10", out_cr_staging, 0);
    check("dly_pending", done, 0);
    in_cycle = 16'd11;
    do_op(OP_PHASE1, '0);
    check("dly_cr11", out_cr_staging, 0);
    in_cycle = 16'd12;
    do_op(OP_PHASE1, '0);
    check("dly_cr12", out_cr_staging, slot(1, cr(1)));
    check("dly_done", done, 1);
    init(3, 3, 2, 0);
    for (int i = 0; i < 5; i++) begin
      in_staging = slot(1, flit(0, 5, 16'h50 + i));
      route(20 + i);
      check($sformatf("cred_out%0d", i), out_staging, (i < 4) ? slot(2, flit(0, 5, 16'h50 + i)) : '0);
    end
    in_cr_staging = slot(2, cr(0));
    route(30);
    check("cred_release", out_staging, slot(2, flit(0, 5, 16'h54)));
    init(4, 4, 2, 0);
    load_rt(7, 3);
    in_staging = slot(1, flit(0, 7, 16'h11)) | slot(2, flit(0, 7, 16'h21));
    route(40);
    check("rr_first", out_staging, slot(3, flit(0, 7, 16'h11)));
    in_staging = slot(1, flit(0, 7, 16'h12));
    route(41);
    check("rr_second", out_staging, slot(3, flit(0, 7, 16'h21)));
    route(42);
    check("rr_third", out_staging, slot(3, flit(0, 7, 16'h12)));
    init(3, 3, 2, 0);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("fill_inj%0d", i), can_inject, 4'b0011);
      in_staging = slot(0, flit(1, 5, 16'h60 + i));
      do_op(OP_LOAD_STG, '0);
    end
    check("full_inj", can_inject, 4'b0001);
    do_op(OP_PHASE0, '0);
    do_op(OP_PHASE1, '0);
    check("pop_out", out_staging, slot(2, flit(1, 5, 16'h60)));
    check("pop_inj", can_inject, 4'b0011);
    check("pop_cr", out_cr_staging, slot(0, cr(1)));
    check("mid_busy", done, 0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("mid_done", done, 1);
    check("mid_out", out_staging, 0);
    check("mid_cr", out_cr_staging, 0);
    check("mid_inj", can_inject, 0);
    @(negedge clk);
    rst = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
